// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, FSM state encodings,
// ALU-controller op codes, datapath select codes and the decoded control bundle.
package mips_pkg;

  // IR[31:26] opcodes handled by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Encodings 12..15 are unused and recover to StFetch
  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic       SRC_A_PC  = 1'b0;
  localparam logic       SRC_A_REG = 1'b1;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Ungated per-state control values. wait_ready marks a state whose pc_write/ir_write
  // only fire once memory reports ready.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       wait_ready;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Pure combinational state -> control decode for the multi-cycle MIPS controller.
// Ports:
//   state - current FSM state
//   ctrl  - ungated control values for that state (enable/memory gating done by the caller)
module multicycle_ctrl_decode
  import mips_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      StFetch: begin
        ctrl.mem_read   = 1'b1;
        ctrl.i_or_d     = 1'b0;
        ctrl.alu_src_a  = SRC_A_PC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.pc_source  = PC_SRC_ALU;
        ctrl.ir_write   = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.wait_ready = 1'b1;
      end
      StDecode: begin
        // Precompute the branch target while the opcode is decoded
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      StMemAddr, StAddiExec: begin
        ctrl.alu_src_a = SRC_A_REG;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      StMemRead: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      StMemWrite: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      StRExec: begin
        ctrl.alu_src_a = SRC_A_REG;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      StRWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = SRC_A_REG;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      StAddiWb: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   en                - 1 advances the FSM; 0 holds state and suppresses all write strobes
//   opcode            - IR[31:26], sampled in DECODE and MEM_ADDR only
//   mem_ready         - unified memory finished its access this cycle
//   pc_write .. pc_source - datapath enables and mux selects
//   illegal_op        - one-cycle pulse when DECODE sees an unsupported opcode
//   state             - current state, for debug
module multicycle_control_fsm
  import mips_pkg::*;
#(
  parameter int unsigned OPW     = 6,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [OPW-1:0]     opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   op_legal;

  multicycle_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  always_comb begin
    op_legal = 1'b1;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (en && mem_ready) state_d = StDecode;
      StDecode: begin
        if (en) begin
          case (opcode)
            OP_LW, OP_SW: state_d = StMemAddr;
            OP_RTYPE:     state_d = StRExec;
            OP_BEQ:       state_d = StBranch;
            OP_J:         state_d = StJump;
            OP_ADDI:      state_d = StAddiExec;
            default:      state_d = StFetch;
          endcase
        end
      end
      StMemAddr: begin
        if (en) begin
          if (opcode == OP_LW)      state_d = StMemRead;
          else if (opcode == OP_SW) state_d = StMemWrite;
          else                      state_d = StFetch;
        end
      end
      StMemRead:  if (en && mem_ready) state_d = StMemWb;
      StMemWrite: if (en && mem_ready) state_d = StFetch;
      StRExec:    if (en) state_d = StRWb;
      StAddiExec: if (en) state_d = StAddiWb;
      StMemWb, StRWb, StAddiWb, StBranch, StJump: if (en) state_d = StFetch;
      // Unused encodings recover regardless of en
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    pc_write      = en & ctrl.pc_write & (mem_ready | ~ctrl.wait_ready);
    ir_write      = en & ctrl.ir_write & mem_ready;
    pc_write_cond = en & ctrl.pc_write_cond;
    reg_write     = en & ctrl.reg_write;
    mem_write     = en & ctrl.mem_write;
    illegal_op    = en & (state_q == StDecode) & ~op_legal;
    i_or_d        = ctrl.i_or_d;
    mem_read      = ctrl.mem_read;
    mem_to_reg    = ctrl.mem_to_reg;
    reg_dst       = ctrl.reg_dst;
    alu_src_a     = ctrl.alu_src_a;
    alu_src_b     = ctrl.alu_src_b;
    alu_op        = ctrl.alu_op;
    pc_source     = ctrl.pc_source;
    // In reset only the fetch read request is visible; no strobe or select leaks out
    if (!rst_n) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      illegal_op    = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b1;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
    end
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n, en, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int n_vec = 0;
  int n_err = 0;

  multicycle_control_fsm #(.OPW(6), .STATE_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
  //  reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], illegal_op}
  logic [16:0] ctrl_bus;
  assign ctrl_bus = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                     reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  localparam logic [16:0] B_RST       = 17'b0_0_0_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] B_FETCH_RDY = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] B_FETCH_NR  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] B_DEC       = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] B_DEC_ILL   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] B_ADDR      = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] B_MRD       = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] B_MWB       = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] B_MWR       = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] B_MWR_EN0   = 17'b0_0_1_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] B_REX       = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] B_RWB       = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] B_RWB_EN0   = 17'b0_0_0_0_0_0_0_1_0_0_00_00_00_0;
  localparam logic [16:0] B_BR        = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] B_JMP       = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] B_AWB       = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: apply inputs at negedge, check state and controls, next posedge advances
  task automatic cyc(input string tag, input logic e, input logic mr, input logic [5:0] op,
                     input logic [3:0] st, input logic [16:0] bits);
    @(negedge clk);
    en = e;
    mem_ready = mr;
    opcode = op;
    #1;
    check({tag, "/state"}, 32'(state), 32'(st));
    check({tag, "/ctrl"}, 32'(ctrl_bus), 32'(bits));
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    mem_ready = 1'b1;
    opcode = R;
    #3;
    check("rst/state", 32'(state), 32'd0);
    check("rst/ctrl", 32'(ctrl_bus), 32'(B_RST));
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("rel/ctrl", 32'(ctrl_bus), 32'(B_FETCH_NR));

    // lw, no wait states: 5 cycles
    cyc("lw_f",  1, 1, LW, 4'd0, B_FETCH_RDY);
    cyc("lw_d",  1, 1, LW, 4'd1, B_DEC);
    cyc("lw_a",  1, 1, LW, 4'd2, B_ADDR);
    cyc("lw_r",  1, 1, LW, 4'd3, B_MRD);
    cyc("lw_wb", 1, 1, LW, 4'd4, B_MWB);
    // sw with two wait cycles; garbage opcode in FETCH is ignored
    cyc("sw_f",  1, 1, BAD, 4'd0, B_FETCH_RDY);
    cyc("sw_d",  1, 1, SW, 4'd1, B_DEC);
    cyc("sw_a",  1, 1, SW, 4'd2, B_ADDR);
    cyc("sw_w0", 1, 0, SW, 4'd5, B_MWR);
    cyc("sw_w1", 1, 0, SW, 4'd5, B_MWR);
    cyc("sw_w2", 1, 1, SW, 4'd5, B_MWR);
    // R-type then beq
    cyc("r_f",   1, 1, R, 4'd0, B_FETCH_RDY);
    cyc("r_d",   1, 1, R, 4'd1, B_DEC);
    cyc("r_x",   1, 1, R, 4'd6, B_REX);
    cyc("r_wb",  1, 1, R, 4'd7, B_RWB);
    cyc("beq_f", 1, 1, BEQ, 4'd0, B_FETCH_RDY);
    cyc("beq_d", 1, 1, BEQ, 4'd1, B_DEC);
    cyc("beq_b", 1, 1, BEQ, 4'd8, B_BR);
    // j and addi
    cyc("j_f",   1, 1, J, 4'd0, B_FETCH_RDY);
    cyc("j_d",   1, 1, J, 4'd1, B_DEC);
    cyc("j_j",   1, 1, J, 4'd9, B_JMP);
    cyc("ad_f",  1, 1, ADDI, 4'd0, B_FETCH_RDY);
    cyc("ad_d",  1, 1, ADDI, 4'd1, B_DEC);
    cyc("ad_x",  1, 1, ADDI, 4'd10, B_ADDR);
    cyc("ad_wb", 1, 1, ADDI, 4'd11, B_AWB);
    // illegal opcode: single pulse, back to FETCH
    cyc("il_f",  1, 1, BAD, 4'd0, B_FETCH_RDY);
    cyc("il_d",  1, 1, BAD, 4'd1, B_DEC_ILL);
    cyc("il_f2", 1, 0, BAD, 4'd0, B_FETCH_NR);
    // en=0 in FETCH with memory ready: no strobes, no advance
    cyc("en_f0", 0, 1, R, 4'd0, B_FETCH_NR);
    cyc("en_f1", 1, 1, R, 4'd0, B_FETCH_RDY);
    cyc("en_d",  1, 1, R, 4'd1, B_DEC);
    cyc("en_x0", 0, 1, R, 4'd6, B_REX);
    cyc("en_x1", 0, 1, R, 4'd6, B_REX);
    cyc("en_x2", 0, 1, R, 4'd6, B_REX);
    cyc("en_x3", 1, 1, R, 4'd6, B_REX);
    cyc("en_w0", 0, 1, R, 4'd7, B_RWB_EN0);
    cyc("en_w1", 1, 1, R, 4'd7, B_RWB);
    // sw stalled by en, then async reset mid-MEM_WRITE
    cyc("rs_f",  1, 1, SW, 4'd0, B_FETCH_RDY);
    cyc("rs_d",  1, 1, SW, 4'd1, B_DEC);
    cyc("rs_a",  1, 1, SW, 4'd2, B_ADDR);
    cyc("rs_w0", 1, 0, SW, 4'd5, B_MWR);
    cyc("rs_w1", 0, 1, SW, 4'd5, B_MWR_EN0);
    cyc("rs_w2", 1, 0, SW, 4'd5, B_MWR);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst/state", 32'(state), 32'd0);
    check("arst/mem_write", 32'(mem_write), 32'd0);
    check("arst/mem_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("arel/state", 32'(state), 32'd0);
    cyc("arel_f", 1, 1, LW, 4'd0, B_FETCH_RDY);
    cyc("arel_d", 1, 1, LW, 4'd1, B_DEC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
